psum_accumulator: RTL and testbench

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/cnn_pkg.sv | 14 +
 rtl/sat_add.sv | 21 ++
 rtl/psum_accumulator.sv | 147 ++++++++++++++
 tb/tb_psum_accumulator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the partial-sum accumulation datapath:
// default word widths and the accumulator FSM state encoding.
package cnn_pkg;

  localparam int PROD_W_DEF = 20;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder. The sum is formed one bit wider than the operands
// so the carry-out can be seen; on carry the result clamps to all-ones.
module sat_add #(
  parameter int ACC_WIDTH = 24
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 ovf
);

  logic [ACC_WIDTH:0] raw;

  // Widened add, then clamp on carry-out.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    ovf = raw[ACC_WIDTH];
    sum = ovf ? {ACC_WIDTH{1'b1}} : raw[ACC_WIDTH-1:0];
  end

endmodule

// File: rtl/psum_accumulator.sv
// Window accumulator for PE product streams.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | no window open; next beat adds onto bias
//   ST_ACCUM | window open; next beat adds onto running sum
//
// The result register is a single-entry skid: input is stalled only while a
// result is held and not being consumed, so a last beat may land in the same
// cycle the previous result leaves.
module psum_accumulator
  import cnn_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_W_DEF,
  parameter int ACC_WIDTH  = ACC_W_DEF,
  parameter int CNT_WIDTH  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prod_valid,
  input  logic [PROD_WIDTH-1:0] prod_data,
  input  logic                  prod_last,
  output logic                  prod_ready,
  input  logic [ACC_WIDTH-1:0]  bias,
  output logic                  acc_valid,
  output logic [ACC_WIDTH-1:0]  acc_data,
  output logic                  acc_sat,
  output logic [CNT_WIDTH-1:0]  acc_count,
  input  logic                  acc_ready
);

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic                 valid_q, valid_d;
  logic [ACC_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0] ocnt_q, ocnt_d;
  logic                 osat_q, osat_d;

  logic                 beat;
  logic [ACC_WIDTH-1:0] add_a;
  logic [ACC_WIDTH-1:0] add_b;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_ovf;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 beat_sat;

  assign prod_ready = !(valid_q && !acc_ready);
  assign beat       = prod_valid && prod_ready;

  assign add_a = (state_q == ST_IDLE) ? bias : acc_q;
  assign add_b = ACC_WIDTH'(prod_data);

  sat_add #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_sat_add (
    .a  (add_a),
    .b  (add_b),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // Beat count and sticky saturation as they stand after the current beat.
  always_comb begin
    if (state_q == ST_IDLE) begin
      beat_cnt = CNT_WIDTH'(1);
      beat_sat = add_ovf;
    end else begin
      beat_cnt = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
      beat_sat = sat_q || add_ovf;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: any accepted beat opens or continues a window; last closes it.
  always_comb begin
    state_d = state_q;
    if (beat) begin
      state_d = prod_last ? ST_IDLE : ST_ACCUM;
    end
  end

  // Datapath and result register next values.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    data_d  = data_q;
    ocnt_d  = ocnt_q;
    osat_d  = osat_q;
    if (beat && prod_last) begin
      data_d  = add_sum;
      ocnt_d  = beat_cnt;
      osat_d  = beat_sat;
      valid_d = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      if (beat) begin
        acc_d = add_sum;
        cnt_d = beat_cnt;
        sat_d = beat_sat;
      end
      if (valid_q && acc_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ocnt_q  <= '0;
      osat_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ocnt_q  <= ocnt_d;
      osat_q  <= osat_d;
    end
  end

  assign acc_valid = valid_q;
  assign acc_data  = data_q;
  assign acc_sat   = osat_q;
  assign acc_count = ocnt_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed scenarios followed by random traffic,
// all checked each cycle against a window-level arithmetic model.
module tb_psum_accumulator;

  localparam int PW = 20;
  localparam int AW = 24;
  localparam int CW = 8;
  localparam longint ACC_MAX = (64'd1 << AW) - 1;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prod_valid = 1'b0;
  logic [PW-1:0] prod_data = '0;
  logic          prod_last = 1'b0;
  logic          prod_ready;
  logic [AW-1:0] bias = '0;
  logic          acc_valid;
  logic [AW-1:0] acc_data;
  logic          acc_sat;
  logic [CW-1:0] acc_count;
  logic          acc_ready = 1'b1;

  int n_compared = 0;
  int n_mismatched = 0;

  // Reference model: window bookkeeping in plain integers.
  bit     m_open;
  longint m_sum;
  int     m_cnt;
  bit     m_sat;
  bit     m_valid;
  longint m_out_data;
  int     m_out_cnt;
  bit     m_out_sat;

  psum_accumulator #(
    .PROD_WIDTH(PW),
    .ACC_WIDTH (AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prod_valid(prod_valid),
    .prod_data (prod_data),
    .prod_last (prod_last),
    .prod_ready(prod_ready),
    .bias      (bias),
    .acc_valid (acc_valid),
    .acc_data  (acc_data),
    .acc_sat   (acc_sat),
    .acc_count (acc_count),
    .acc_ready (acc_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete (observed timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_sum = 0; m_cnt = 0; m_sat = 0;
    m_valid = 0; m_out_data = 0; m_out_cnt = 0; m_out_sat = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, acc_valid, m_valid);
    if (m_valid) begin
      chk({tag, ".data"}, acc_data, m_out_data);
      chk({tag, ".count"}, acc_count, m_out_cnt);
      chk({tag, ".sat"}, acc_sat, m_out_sat);
    end
  endtask

  // One clock: drive at negedge, check ready, advance model, check outputs.
  task automatic step(input string tag, input bit v, input logic [PW-1:0] d,
                      input bit l, input bit r, input logic [AW-1:0] b);
    bit     ready_exp;
    bit     accepted;
    prod_valid = v;
    prod_data  = d;
    prod_last  = l;
    acc_ready  = r;
    bias       = b;
    #1;
    ready_exp = !(m_valid && !r);
    chk({tag, ".prod_ready"}, prod_ready, ready_exp);
    accepted = v && ready_exp;
    if (accepted) begin
      if (!m_open) begin
        m_sum = b; m_cnt = 0; m_sat = 0;
      end
      m_sum = m_sum + d;
      if (m_sum > ACC_MAX) begin
        m_sum = ACC_MAX;
        m_sat = 1;
      end
      if (m_cnt < CNT_MAX) m_cnt++;
      if (l) begin
        m_out_data = m_sum; m_out_cnt = m_cnt; m_out_sat = m_sat;
        m_valid = 1; m_open = 0;
      end else begin
        m_open = 1;
        if (m_valid && r) m_valid = 0;
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle_step(input string tag);
    step(tag, 0, '0, 0, 1, '0);
  endtask

  // Async reset asserted at negedge; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, ".valid0"}, acc_valid, 0);
    chk({tag, ".data0"}, acc_data, 0);
    chk({tag, ".count0"}, acc_count, 0);
    chk({tag, ".sat0"}, acc_sat, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, ".ready_after_rst"}, prod_ready, 1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset("rst_init");

    // Three beats, bias 0; result visible exactly one cycle.
    step("w357.b0", 1, 20'd3, 0, 1, 24'd0);
    step("w357.b1", 1, 20'd5, 0, 1, 24'd999);
    step("w357.b2", 1, 20'd7, 1, 1, 24'd999);
    chk("w357.sum", acc_data, 15);
    chk("w357.cnt", acc_count, 3);
    idle_step("w357.drop");

    // Single-beat window.
    step("single", 1, 20'd25, 1, 1, 24'd100);
    chk("single.sum", acc_data, 125);
    chk("single.cnt", acc_count, 1);
    idle_step("single.drop");

    // Saturating window, then sticky flag clears for the next window.
    step("sat.b0", 1, 20'hFFFFF, 0, 1, 24'hFFFFF6);
    step("sat.b1", 1, 20'd4, 1, 1, 24'd0);
    chk("sat.sum", acc_data, 24'hFFFFFF);
    chk("sat.flag", acc_sat, 1);
    step("nosat", 1, 20'd1, 1, 1, 24'd0);
    chk("nosat.sum", acc_data, 1);
    chk("nosat.flag", acc_sat, 0);
    idle_step("nosat.drop");

    // Back-pressure: result held for 5 cycles while beats are offered.
    step("bp.res", 1, 20'd42, 1, 0, 24'd8);
    for (int i = 0; i < 5; i++) step("bp.hold", 1, 20'd77, 1, 0, 24'd0);
    chk("bp.held_data", acc_data, 50);
    step("bp.consume", 0, '0, 0, 1, 24'd0);
    step("bp.resume", 1, 20'd6, 1, 1, 24'd1);
    chk("bp.resume_sum", acc_data, 7);
    idle_step("bp.drop");

    // Back-to-back singles, no bubble.
    for (int i = 1; i <= 4; i++) begin
      step("b2b", 1, PW'(i), 1, 1, 24'd0);
      chk("b2b.sum", acc_data, i);
    end
    idle_step("b2b.drop");

    // Reset mid-window discards the partial sum.
    step("mid.b0", 1, 20'd500, 0, 1, 24'd3);
    step("mid.b1", 1, 20'd600, 0, 1, 24'd3);
    do_reset("rst_mid");
    step("post.b0", 1, 20'd9, 0, 1, 24'd0);
    step("post.b1", 1, 20'd1, 1, 1, 24'd0);
    chk("post.sum", acc_data, 10);
    chk("post.cnt", acc_count, 2);
    idle_step("post.drop");

    // Long window: beat counter saturates.
    for (int i = 0; i < 259; i++) step("long", 1, 20'd1, 0, 1, 24'd0);
    step("long.last", 1, 20'd1, 1, 1, 24'd0);
    chk("long.cnt", acc_count, CNT_MAX);
    chk("long.sum", acc_data, 260);
    idle_step("long.drop");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit            v, l, r;
      logic [PW-1:0] d;
      logic [AW-1:0] b;
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) < 7);
      d = ($urandom_range(0, 3) == 0) ? PW'($urandom) : PW'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 1000));
      step("rand", v, d, l, r, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
